// File: rtl/mac_stream_sink.sv
// Sink end of the MAC operand stream: multiplies each (a,b) beat in a registered
// product stage, accumulates per packet and presents the packet result on a held port.
module mac_stream_sink #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 16,
  parameter int MAX_LEN = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [DATA_W-1:0]                  s_a,
  input  logic [DATA_W-1:0]                  s_b,
  input  logic                               s_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [ACC_W-1:0]                   m_sum,
  output logic [$clog2(MAX_LEN+1)-1:0]       m_count,
  output logic                               m_overflow,
  output logic                               m_forced
);

  localparam int CNT_W  = $clog2(MAX_LEN+1);
  localparam int PROD_W = 2 * DATA_W;
  // One guard bit above the wider of acc/prod captures both overflow sources.
  localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_OUTPUT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                prod_vld_q, prod_vld_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                forced_q, forced_d;

  logic                xfer;
  logic [SUM_W-1:0]    sum_full;

  assign xfer     = s_valid & s_ready;
  assign sum_full = SUM_W'(acc_q) + SUM_W'(prod_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      forced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      forced_q   <= forced_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prod_d     = prod_q;
    prod_vld_d = 1'b0;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    forced_d   = forced_q;

    // Accumulate whichever product was registered on the previous edge.
    if (prod_vld_q) begin
      acc_d = sum_full[ACC_W-1:0];
      if (|sum_full[SUM_W-1:ACC_W]) begin
        ovf_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_ACCUM: begin
        if (xfer) begin
          prod_d     = PROD_W'(s_a) * PROD_W'(s_b);
          prod_vld_d = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          if (s_last || (cnt_q == CNT_W'(MAX_LEN - 1))) begin
            state_d  = ST_DRAIN;
            forced_d = ~s_last;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (m_ready) begin
          state_d  = ST_ACCUM;
          acc_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          forced_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // Ready is gated by rst_n so it reads low for the whole reset pulse.
  assign s_ready    = rst_n & (state_q == ST_ACCUM);
  assign m_valid    = (state_q == ST_OUTPUT);
  assign m_sum      = acc_q;
  assign m_count    = cnt_q;
  assign m_overflow = ovf_q;
  assign m_forced   = forced_q;

endmodule

// File: tb/tb_mac_stream_sink.sv
// Randomized scoreboard bench for mac_stream_sink: a packet-level reference model
// queues expected results, an independent monitor checks each presented result.
module tb_mac_stream_sink;
  localparam int DATA_W  = 8;
  localparam int ACC_W   = 16;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = $clog2(MAX_LEN+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_a = '0;
  logic [DATA_W-1:0] s_b = '0;
  logic              s_last = 1'b0;
  logic              m_valid;
  logic              m_ready;
  logic [ACC_W-1:0]  m_sum;
  logic [CNT_W-1:0]  m_count;
  logic              m_overflow;
  logic              m_forced;

  mac_stream_sink #(.DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_count(m_count),
    .m_overflow(m_overflow), .m_forced(m_forced)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cnt;
    bit ovf;
    bit frc;
    int cyc;
  } exp_t;

  exp_t    expq[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      cyc = 0;
  longint  cur_sum = 0;
  int      cur_cnt = 0;
  int      close_cyc = -10;
  int      ready_chk_cyc = -10;
  bit      seen = 0;
  int      hold_cnt = 0;
  bit      rand_ready = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Packet-level reference: the result is the plain integer dot product.
  function automatic void model_accept(input int a, input int b, input bit last);
    exp_t e;
    if (cyc == close_cyc + 1) chk("accept_during_drain", 1, 0);
    cur_sum += a * b;
    cur_cnt++;
    if (last || cur_cnt == MAX_LEN) begin
      e.sum = int'(cur_sum % (64'd1 << ACC_W));
      e.cnt = cur_cnt;
      e.ovf = (cur_sum >= (64'd1 << ACC_W));
      e.frc = (cur_cnt == MAX_LEN) && !last;
      e.cyc = cyc;
      expq.push_back(e);
      $display("packet closed: beats=%0d sum=%0d ovf=%0d forced=%0d", e.cnt, e.sum, e.ovf, e.frc);
      cur_sum   = 0;
      cur_cnt   = 0;
      close_cyc = cyc;
    end
  endfunction

  // Monitor: compares every held-result cycle against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_m_valid", 1, 0);
        end else begin
          if (!seen) begin
            chk("latency_cycle", cyc, expq[0].cyc + 2);
            seen = 1;
          end
          chk("m_sum", m_sum, expq[0].sum);
          chk("m_count", m_count, expq[0].cnt);
          chk("m_overflow", m_overflow, expq[0].ovf);
          chk("m_forced", m_forced, expq[0].frc);
          chk("s_ready_while_valid", s_ready, 0);
          if (m_ready) begin
            $display("result: sum=%0d count=%0d ovf=%0d forced=%0d", m_sum, m_count, m_overflow, m_forced);
            void'(expq.pop_front());
            seen = 0;
            ready_chk_cyc = cyc + 1;
          end
        end
      end
      if (cyc == ready_chk_cyc) chk("s_ready_after_handshake", s_ready, 1);
    end
  end

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_cnt > 0) begin
        m_ready = 1'b0;
        if (m_valid) hold_cnt--;
      end else if (rand_ready) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // All drive tasks start and end at posedge+1.
  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin
      s_a = DATA_W'($urandom);
      s_b = DATA_W'($urandom);
      s_last = 1'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input int a, input int b, input bit last);
    int w = 0;
    s_valid = 1'b1;
    s_a = DATA_W'(a);
    s_b = DATA_W'(b);
    s_last = last;
    @(negedge clk);
    while (!s_ready) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      w++;
      if (w > 300) begin
        chk("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        return;
      end
    end
    model_accept(a, b, last);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((expq.size() != 0 || m_valid) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 500) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_sum"}, m_sum, 0);
    chk({tag, "_m_count"}, m_count, 0);
    chk({tag, "_m_overflow"}, m_overflow, 0);
    chk({tag, "_m_forced"}, m_forced, 0);
  endtask

  initial begin
    int len;
    bit lst;
    #3;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", s_ready, 1);
    @(posedge clk);
    #1;

    // 1: squares 0..9, immediate m_ready
    for (int i = 0; i < 10; i++) beat(i, i, i == 9);
    wait_idle();

    // 2: same packet, result held for 5 cycles, next packet right behind
    hold_cnt = 5;
    for (int i = 0; i < 10; i++) beat(i, i, i == 9);
    beat(7, 9, 1'b1);
    wait_idle();

    // 3: overflow packet then clean packet
    beat(255, 255, 1'b0);
    beat(255, 255, 1'b1);
    beat(3, 4, 1'b1);
    wait_idle();

    // 4: forced close at MAX_LEN; 17th beat waits for the handshake
    for (int i = 0; i < MAX_LEN; i++) beat(1, 1, 1'b0);
    beat(5, 6, 1'b1);
    wait_idle();

    // MAX_LEN beats with last on the final one: not forced
    for (int i = 0; i < MAX_LEN; i++) beat(200, 200, i == MAX_LEN - 1);
    wait_idle();

    // 5: random gaps, lengths and m_ready
    rand_ready = 1;
    for (int p = 0; p < 40; p++) begin
      len = (p % 5 == 0) ? 1 : $urandom_range(1, MAX_LEN + 2);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        lst = (k == len - 1);
        beat($urandom_range(0, 255), $urandom_range(0, 255), lst);
      end
    end
    wait_idle();
    rand_ready = 0;

    // 6: reset after 4 beats discards the partial packet
    for (int i = 0; i < 4; i++) beat(10 + i, 20 + i, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    cur_sum = 0;
    cur_cnt = 0;
    seen = 0;
    ready_chk_cyc = -10;
    close_cyc = -10;
    @(posedge clk);
    #1;
    check_all_zero("midreset_held");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    beat(2, 3, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
